// File: rtl/div_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_detect_pkg
// Description : Shared types and default constants for the divide-ratio
//               detector: FSM state encoding, default parameter values and
//               the fault-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package div_detect_pkg;

    localparam int DEF_MAX_DIV  = 64;
    localparam int DEF_LOCK_CNT = 3;
    localparam int ERR_CNT_W    = 16;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } det_state_e;

endpackage : div_detect_pkg
`default_nettype wire

// File: rtl/sig_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sig_edge_det
// Description : One-cycle delay of the sampled waveform plus rise/fall
//               strobes derived from the current and delayed samples.
// Revision    : 1.0 - initial release
// Ports       : clk     - clock
//               resetn  - synchronous active-low reset (clears delayed sample)
//               sig_i   - waveform synchronous to clk
//               rise_o  - sig_i high, previous sample low
//               fall_o  - sig_i low, previous sample high
// ============================================================================
module sig_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_d_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_d_q;
    assign fall_o = ~sig_i & sig_d_q;

endmodule : sig_edge_det
`default_nettype wire

// File: rtl/div_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module      : div_ratio_detector
// Description : Measures high/low run lengths of a divided waveform, reports
//               the even divide ratio, asserts lock after LOCK_CNT equal
//               periods and flags duty-cycle and stuck-level faults.
// Revision    : 1.0 - initial release
// Config      : DIV_RATIO_DETECTOR_ERR_CNT_EN - when defined, err_cnt is a
//               saturating count of fault pulses; otherwise tied to zero.
// Ports       : clk          - clock
//               resetn       - synchronous active-low reset
//               en           - enable; low forces SYNC, clears lock state
//               sig_in       - divided waveform, synchronous to clk
//               ratio_o      - last valid period (high_len + low_len)
//               ratio_valid  - pulse: ratio_o refreshed by a 50% period
//               locked       - LOCK_CNT consecutive equal valid periods
//               err_duty     - pulse: period completed with unequal halves
//               err_timeout  - pulse: level held beyond MAX_DIV/2 cycles
//               err_cnt      - saturating fault counter
// ============================================================================
module div_ratio_detector
    import div_detect_pkg::*;
#(
    parameter  int MAX_DIV  = DEF_MAX_DIV,
    parameter  int LOCK_CNT = DEF_LOCK_CNT,
    localparam int CNT_W    = $clog2(MAX_DIV + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic                 sig_in,
    output logic [CNT_W-1:0]     ratio_o,
    output logic                 ratio_valid,
    output logic                 locked,
    output logic                 err_duty,
    output logic                 err_timeout,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    // Run counter saturates one past the longest legal level so a stuck
    // level is recognisable without the counter wrapping.
    localparam logic [CNT_W-1:0]   RUN_MAX   = CNT_W'(MAX_DIV / 2 + 1);
    localparam logic [CNT_W-1:0]   RUN_ONE   = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_LCK = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

    logic w_rise;
    logic w_fall;
    logic w_edge;

    sig_edge_det u_edge (
        .clk    (clk),
        .resetn (resetn),
        .sig_i  (sig_in),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    assign w_edge = w_rise | w_fall;

    det_state_e         state_q, state_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   high_len_q, high_len_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   ratio_q, ratio_d;
    logic               ratio_valid_q, ratio_valid_d;
    logic               locked_q, locked_d;
    logic               err_duty_q, err_duty_d;
    logic               err_timeout_q, err_timeout_d;

    logic               w_close;    // closing rise of a complete period
    logic               w_timeout;  // level held past RUN_MAX with no edge
    logic [CNT_W:0]     w_period;
    logic               w_halves_eq;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        high_len_d = high_len_q;
        w_close    = 1'b0;
        w_timeout  = 1'b0;
        if (!en) begin
            state_d = SYNC;
        end else begin
            case (state_q)
                SYNC: begin
                    // The level in progress at entry has unknown length.
                    if (w_rise) begin
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        state_d    = LOW;
                        high_len_d = run_cnt_q;
                    end else if (!w_edge && (run_cnt_q == RUN_MAX)) begin
                        state_d   = SYNC;
                        w_timeout = 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        state_d = HIGH;
                        w_close = 1'b1;
                    end else if (!w_edge && (run_cnt_q == RUN_MAX)) begin
                        state_d   = SYNC;
                        w_timeout = 1'b1;
                    end
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    // On the closing rise run_cnt_q still holds the low length.
    assign w_period    = {1'b0, high_len_q} + {1'b0, run_cnt_q};
    assign w_halves_eq = (high_len_q == run_cnt_q);

    always_comb begin
        run_cnt_d     = run_cnt_q;
        match_cnt_d   = match_cnt_q;
        ratio_d       = ratio_q;
        ratio_valid_d = 1'b0;
        locked_d      = locked_q;
        err_duty_d    = 1'b0;
        err_timeout_d = 1'b0;

        if (!en) begin
            run_cnt_d   = '0;
            match_cnt_d = '0;
            locked_d    = 1'b0;
        end else begin
            if (w_edge) begin
                run_cnt_d = RUN_ONE;
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_d = run_cnt_q + RUN_ONE;
            end

            if (w_timeout) begin
                err_timeout_d = 1'b1;
                locked_d      = 1'b0;
                match_cnt_d   = '0;
            end else if (w_close) begin
                if (w_halves_eq) begin
                    ratio_d       = w_period[CNT_W-1:0];
                    ratio_valid_d = 1'b1;
                    // ratio_q is the previous valid period; after a fault
                    // match_cnt is zero so a repeat still restarts at one.
                    if (w_period == {1'b0, ratio_q}) begin
                        if (match_cnt_q != MATCH_LCK) begin
                            match_cnt_d = match_cnt_q + MATCH_ONE;
                        end
                    end else begin
                        match_cnt_d = MATCH_ONE;
                    end
                    locked_d = (match_cnt_d == MATCH_LCK);
                end else begin
                    err_duty_d  = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_cnt_q     <= '0;
            high_len_q    <= '0;
            match_cnt_q   <= '0;
            ratio_q       <= '0;
            ratio_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_duty_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            high_len_q    <= high_len_d;
            match_cnt_q   <= match_cnt_d;
            ratio_q       <= ratio_d;
            ratio_valid_q <= ratio_valid_d;
            locked_q      <= locked_d;
            err_duty_q    <= err_duty_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign ratio_o     = ratio_q;
    assign ratio_valid = ratio_valid_q;
    assign locked      = locked_q;
    assign err_duty    = err_duty_q;
    assign err_timeout = err_timeout_q;

    // ------------------------------------------------------------------
    // Optional fault counter (not cleared by en)
    // ------------------------------------------------------------------
`ifdef DIV_RATIO_DETECTOR_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else if ((err_duty_q | err_timeout_q) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule : div_ratio_detector
`default_nettype wire

// File: tb/tb_div_ratio_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ratio_detector
// Description : Self-checking bench for div_ratio_detector. Expected pulses
//               (kind, ratio, lock state, cycle) are queued when the closing
//               edge is driven and compared when the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ratio_detector;

    localparam int MAX_DIV  = 64;
    localparam int LOCK_CNT = 3;
    localparam int CNT_W    = $clog2(MAX_DIV + 1);
    localparam int TMO      = MAX_DIV / 2 + 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] ratio_o;
    logic             ratio_valid;
    logic             locked;
    logic             err_duty;
    logic             err_timeout;
    logic [15:0]      err_cnt;

    div_ratio_detector #(
        .MAX_DIV  (MAX_DIV),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .en          (en),
        .sig_in      (sig_in),
        .ratio_o     (ratio_o),
        .ratio_valid (ratio_valid),
        .locked      (locked),
        .err_duty    (err_duty),
        .err_timeout (err_timeout),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int unsigned pe = 0;
    always @(posedge clk) pe <= pe + 1;

    // kind bits: {ratio_valid, err_duty, err_timeout}
    typedef struct {
        logic [2:0]  kind;
        int          ratio;
        bit          lck;
        int unsigned t;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model of the period history
    int m_prev  = 0;
    int m_match = 0;
    int m_errs  = 0;
    bit pend    = 1'b0;
    int pend_h  = 0;
    int pend_l  = 0;
    bit last_v  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic close_period();
        exp_t e;
        int   per;
        e.t = pe;
        if (pend_h == pend_l) begin
            per = pend_h + pend_l;
            if (per == m_prev) m_match = (m_match < LOCK_CNT) ? m_match + 1 : LOCK_CNT;
            else               m_match = 1;
            m_prev  = per;
            e.kind  = 3'b100;
            e.ratio = per;
            e.lck   = (m_match == LOCK_CNT);
        end else begin
            m_match = 0;
            m_errs++;
            e.kind  = 3'b010;
            e.ratio = m_prev;
            e.lck   = 1'b0;
        end
        q.push_back(e);
        pend = 1'b0;
    endtask

    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk);
        #1;
        if (v && !last_v && pend) close_period();
        last_v = v;
    endtask

    task automatic period(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
        pend   = 1'b1;
        pend_h = h;
        pend_l = l;
    endtask

    task automatic en_pulse();
        pend    = 1'b0;
        m_match = 0;
        en      = 1'b0;
        step(1'b0);
        step(1'b0);
        check("locked_en0", {31'd0, locked}, 32'd0);
        en = 1'b1;
        step(1'b0);
    endtask

    // Scoreboard: every fault/valid pulse must match the head of the queue.
    always @(negedge clk) begin
        if (ratio_valid || err_duty || err_timeout) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind=%b ratio=%0d at edge %0d, none expected",
                         {ratio_valid, err_duty, err_timeout}, ratio_o, pe);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (({ratio_valid, err_duty, err_timeout} !== e.kind) ||
                    (ratio_o !== CNT_W'(e.ratio)) || (locked !== e.lck) || (pe != e.t)) begin
                    errors++;
                    $display("FAIL pulse: got kind=%b ratio=%0d locked=%b edge=%0d, expected kind=%b ratio=%0d locked=%b edge=%0d",
                             {ratio_valid, err_duty, err_timeout}, ratio_o, locked, pe,
                             e.kind, e.ratio, e.lck, e.t);
                end
            end
        end
    end

    typedef struct {
        int h;
        int l;
        int n;
        int exp_ratio;
        bit exp_locked;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{h: 1,  l: 1,  n: 4, exp_ratio: 2,  exp_locked: 1'b1};
        vecs[1] = '{h: 3,  l: 3,  n: 4, exp_ratio: 6,  exp_locked: 1'b1};
        vecs[2] = '{h: 3,  l: 1,  n: 3, exp_ratio: 6,  exp_locked: 1'b0};
        vecs[3] = '{h: 2,  l: 2,  n: 2, exp_ratio: 4,  exp_locked: 1'b0};
        vecs[4] = '{h: 16, l: 16, n: 3, exp_ratio: 32, exp_locked: 1'b1};
        vecs[5] = '{h: 32, l: 32, n: 3, exp_ratio: 64, exp_locked: 1'b1};
        vecs[6] = '{h: 33, l: 1,  n: 1, exp_ratio: 64, exp_locked: 1'b0};
        vecs[7] = '{h: 1,  l: 2,  n: 2, exp_ratio: 64, exp_locked: 1'b0};

        resetn = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ratio",   {25'd0, ratio_o},    32'd0);
        check("rst_valid",   {31'd0, ratio_valid}, 32'd0);
        check("rst_locked",  {31'd0, locked},     32'd0);
        check("rst_duty",    {31'd0, err_duty},   32'd0);
        check("rst_timeout", {31'd0, err_timeout}, 32'd0);
        check("rst_errcnt",  {16'd0, err_cnt},    32'd0);
        resetn = 1'b1;
        en     = 1'b1;
        step(1'b0);

        // Lock on div2, then a one-cycle reset while locked.
        repeat (4) period(1, 1);
        step(1'b1);
        check("pre_rst_locked", {31'd0, locked}, 32'd1);
        pend   = 1'b0;
        resetn = 1'b0;
        step(1'b0);
        resetn  = 1'b1;
        m_prev  = 0;
        m_match = 0;
        m_errs  = 0;
        check("midrst_ratio",  {25'd0, ratio_o},     32'd0);
        check("midrst_locked", {31'd0, locked},      32'd0);
        check("midrst_valid",  {31'd0, ratio_valid}, 32'd0);
        check("midrst_errcnt", {16'd0, err_cnt},     32'd0);
        en_pulse();
        repeat (4) period(1, 1);
        step(1'b1);
        check("relock", {31'd0, locked}, 32'd1);

        // Table of steady-state patterns
        for (int i = 0; i < 8; i++) begin
            en_pulse();
            for (int k = 0; k < vecs[i].n; k++) period(vecs[i].h, vecs[i].l);
            step(1'b1);
            check($sformatf("vec%0d_ratio", i), {25'd0, ratio_o}, vecs[i].exp_ratio);
            check($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].exp_locked});
        end

        // Stuck-high timeout after a sync rise
        en_pulse();
        step(1'b1);
        begin
            exp_t e;
            e.kind  = 3'b001;
            e.ratio = m_prev;
            e.lck   = 1'b0;
            e.t     = pe + TMO;
            q.push_back(e);
            m_match = 0;
            m_errs++;
        end
        repeat (39) step(1'b1);
        step(1'b0);
        step(1'b0);

        // Lock on div4 then switch to div6; lock must drop and recover.
        repeat (4) period(2, 2);
        repeat (3) period(3, 3);
        step(1'b1);
        check("switch_ratio",  {25'd0, ratio_o}, 32'd6);
        check("switch_locked", {31'd0, locked},  32'd1);

        repeat (4) step(1'b1);
        check("queue_drained", q.size(), 32'd0);
`ifdef DIV_RATIO_DETECTOR_ERR_CNT_EN
        check("err_cnt", {16'd0, err_cnt}, m_errs);
`else
        check("err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_div_ratio_detector
`default_nettype wire
